// File: rtl/ebpc_pkg.sv
// Shared types and default widths for the EBPC decoder datapath.
package ebpc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } unpack_state_t;

    localparam int DEF_IN_W  = 32;
    localparam int DEF_OUT_W = 32;
    localparam int DEF_DEPTH = 3;

endpackage

// File: rtl/stream_unpacker_if.sv
// Input-word and output-window handshake bundle of the stream unpacker.
interface stream_unpacker_if #(
    parameter int IN_W   = 32,
    parameter int OUT_W  = 32,
    parameter int DEPTH  = 3,
    parameter int LEN_W  = $clog2(OUT_W) + 1,
    parameter int FILL_W = $clog2(DEPTH * IN_W) + 1
);
    logic [IN_W-1:0]   data_i;
    logic              last_i;
    logic              vld_i;
    logic              rdy_o;
    logic [OUT_W-1:0]  data_o;
    logic [FILL_W-1:0] fill_o;
    logic [LEN_W-1:0]  len_i;
    logic              align_i;
    logic              vld_o;
    logic              rdy_i;
    logic              last_o;

    modport slave (
        input  data_i, last_i, vld_i, len_i, align_i, rdy_i,
        output rdy_o, data_o, fill_o, vld_o, last_o
    );

    modport master (
        output data_i, last_i, vld_i, len_i, align_i, rdy_i,
        input  rdy_o, data_o, fill_o, vld_o, last_o
    );
endinterface

// File: rtl/stream_unpacker_shift.sv
// Combinational variable-amount shifter over the whole buffer, zero-filling.
module stream_unpacker_shift #(
    parameter int W     = 96,
    parameter int AMT_W = 8
) (
    input  logic [W-1:0]     data_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic             left_i,
    output logic [W-1:0]     data_o
);
    always_comb begin
        if (left_i) data_o = data_i << amt_i;
        else        data_o = data_i >> amt_i;
    end
endmodule

// File: rtl/stream_unpacker.sv
// Variable-length bit-stream unpacker: MSB-aligned multi-word buffer, window on top,
// per-transfer consume, word-alignment skip and end-of-stream draining.
module stream_unpacker
    import ebpc_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int LEN_W  = $clog2(OUT_W) + 1,
    parameter int FILL_W = $clog2(DEPTH * IN_W) + 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    stream_unpacker_if.slave bus
);
    localparam int BUF_W = DEPTH * IN_W;
    localparam logic [FILL_W-1:0] IN_W_F     = FILL_W'(IN_W);
    localparam logic [FILL_W-1:0] ROOM_F     = FILL_W'(BUF_W - IN_W);
    localparam logic [FILL_W-1:0] ALIGN_MASK = FILL_W'(IN_W - 1);

    if ((IN_W & (IN_W - 1)) != 0) begin : g_chk_in_pow2
        $error("stream_unpacker: IN_W must be a power of two");
    end
    if (OUT_W > IN_W) begin : g_chk_out_w
        $error("stream_unpacker: OUT_W must not exceed IN_W");
    end
    if (DEPTH < 2) begin : g_chk_depth
        $error("stream_unpacker: DEPTH must be at least 2");
    end

    unpack_state_t     state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d, buf_drop, ins_word, ins_shift;
    logic [FILL_W-1:0] fill_q, fill_d, len_f, take, fill_c, drop_amt, fill_a;
    logic              vld, rdy, out_xfer, in_xfer, align_now;

    assign len_f     = FILL_W'(bus.len_i);
    assign rdy       = !rst_i && !clr_i && (state_q != DRAIN) && (fill_q <= ROOM_F);
    assign out_xfer  = vld && bus.rdy_i;
    assign in_xfer   = bus.vld_i && rdy;
    assign align_now = bus.rdy_i && bus.align_i;

    always_comb begin
        case (state_q)
            RUN:     vld = (fill_q >= len_f) && (fill_q != '0);
            DRAIN:   vld = (fill_q != '0);
            default: vld = 1'b0;
        endcase
    end

    // Consume and align collapse into one left shift; align counts from the post-consume fill.
    assign take     = out_xfer ? ((len_f < fill_q) ? len_f : fill_q) : '0;
    assign fill_c   = fill_q - take;
    assign drop_amt = take + (align_now ? (fill_c & ALIGN_MASK) : '0);
    assign fill_a   = fill_q - drop_amt;
    assign ins_word = {bus.data_i, {(BUF_W - IN_W){1'b0}}};

    stream_unpacker_shift #(.W(BUF_W), .AMT_W(FILL_W)) u_consume (
        .data_i (buf_q),
        .amt_i  (drop_amt),
        .left_i (1'b1),
        .data_o (buf_drop)
    );

    stream_unpacker_shift #(.W(BUF_W), .AMT_W(FILL_W)) u_insert (
        .data_i (ins_word),
        .amt_i  (fill_a),
        .left_i (1'b0),
        .data_o (ins_shift)
    );

    always_comb begin
        buf_d   = in_xfer ? (buf_drop | ins_shift) : buf_drop;
        fill_d  = in_xfer ? (fill_a + IN_W_F) : fill_a;
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_xfer) state_d = bus.last_i ? DRAIN : RUN;
            RUN:     if (in_xfer && bus.last_i) state_d = DRAIN;
            DRAIN:   if (fill_a == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q <= IDLE;
            buf_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && bus.rdy_i) begin
            assert (bus.len_i <= LEN_W'(OUT_W))
            else $error("stream_unpacker: len_i exceeds OUT_W");
        end
    end

    assign bus.rdy_o  = rdy;
    assign bus.vld_o  = vld;
    assign bus.last_o = (state_q == DRAIN) && (fill_q <= len_f) && vld;
    assign bus.data_o = buf_q[BUF_W-1 -: OUT_W];
    assign bus.fill_o = fill_q;
endmodule

// File: tb/tb_stream_unpacker.sv
// Directed plus randomized bench for stream_unpacker against a bit-queue reference model.
module tb_stream_unpacker;
    localparam int IN_W  = 32;
    localparam int OUT_W = 32;
    localparam int DEPTH = 3;
    localparam int BUF_W = IN_W * DEPTH;

    logic clk_i = 1'b0;
    logic rst_i;
    logic clr_i;

    stream_unpacker_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

    stream_unpacker #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    // Reference: the buffered stream is a plain queue of bits, oldest first.
    bit          mq[$];
    bit          m_drain = 1'b0;
    logic        e_vld, e_last, e_rdy;
    logic [31:0] e_data;
    int          e_fill;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_outputs();
        int n;
        int len;
        n      = mq.size();
        len    = int'(bus.len_i);
        e_fill = n;
        e_data = '0;
        for (int i = 0; i < OUT_W && i < n; i++) e_data[OUT_W-1-i] = mq[i];
        e_rdy  = !rst_i && !clr_i && !m_drain && (n <= BUF_W - IN_W);
        e_vld  = m_drain ? (n > 0) : ((n > 0) && (n >= len));
        e_last = m_drain && (n <= len) && e_vld;
    endfunction

    function automatic void model_step();
        int c;
        if (rst_i || clr_i) begin
            mq.delete();
            m_drain = 1'b0;
            return;
        end
        if (e_vld && bus.rdy_i) begin
            c = (int'(bus.len_i) < mq.size()) ? int'(bus.len_i) : mq.size();
            repeat (c) void'(mq.pop_front());
        end
        if (bus.rdy_i && bus.align_i) repeat (mq.size() % IN_W) void'(mq.pop_front());
        if (bus.vld_i && e_rdy) begin
            for (int i = IN_W - 1; i >= 0; i--) mq.push_back(bus.data_i[i]);
            if (bus.last_i) m_drain = 1'b1;
        end
        if (m_drain && mq.size() == 0) m_drain = 1'b0;
    endfunction

    task automatic tick();
        #1;
        model_outputs();
        chk("vld_o",  32'(bus.vld_o),  32'(e_vld));
        chk("last_o", 32'(bus.last_o), 32'(e_last));
        chk("rdy_o",  32'(bus.rdy_o),  32'(e_rdy));
        chk("data_o", bus.data_o,      e_data);
        chk("fill_o", 32'(bus.fill_o), e_fill);
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic set_idle();
        clr_i       = 1'b0;
        bus.vld_i   = 1'b0;
        bus.last_i  = 1'b0;
        bus.data_i  = '0;
        bus.len_i   = '0;
        bus.align_i = 1'b0;
        bus.rdy_i   = 1'b0;
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        set_idle();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);

        // Reset
        chk("rst_data", bus.data_o, 32'h0);
        chk("rst_fill", 32'(bus.fill_o), 32'd0);
        chk("rst_vld", 32'(bus.vld_o), 32'd0);
        chk("rst_last", 32'(bus.last_o), 32'd0);
        chk("rst_rdy", 32'(bus.rdy_o), 32'd0);
        tick();
        rst_i = 1'b0;
        #1;
        chk("rel_rdy", 32'(bus.rdy_o), 32'd1);
        chk("rel_fill", 32'(bus.fill_o), 32'd0);

        // Push two words and consume a nibble
        bus.vld_i = 1'b1; bus.data_i = 32'hDEADBEEF; tick();
        bus.data_i = 32'h12345678; tick();
        set_idle();
        chk("push_fill", 32'(bus.fill_o), 32'd64);
        chk("push_data", bus.data_o, 32'hDEADBEEF);
        bus.rdy_i = 1'b1; bus.len_i = 6'd4; tick();
        set_idle();
        chk("cons_data", bus.data_o, 32'hEADBEEF1);
        chk("cons_fill", 32'(bus.fill_o), 32'd60);

        // Align with zero-length consume
        bus.rdy_i = 1'b1; bus.align_i = 1'b1; tick();
        set_idle();
        chk("align_fill", 32'(bus.fill_o), 32'd32);
        chk("align_data", bus.data_o, 32'h12345678);

        // Length gating at F = 12
        bus.rdy_i = 1'b1; bus.len_i = 6'd20; tick();
        set_idle();
        chk("gate_fill12", 32'(bus.fill_o), 32'd12);
        bus.rdy_i = 1'b1; bus.len_i = 6'd16; #1;
        chk("gate_vld0", 32'(bus.vld_o), 32'd0);
        bus.vld_i = 1'b1; bus.data_i = 32'hCAFEF00D; tick();
        set_idle();
        bus.len_i = 6'd16; #1;
        chk("gate_vld1", 32'(bus.vld_o), 32'd1);
        chk("gate_fill44", 32'(bus.fill_o), 32'd44);
        tick();

        // Clear mid-stream at F = 40
        bus.rdy_i = 1'b1; bus.len_i = 6'd4; tick();
        set_idle();
        chk("clr_pre_fill", 32'(bus.fill_o), 32'd40);
        clr_i = 1'b1; bus.rdy_i = 1'b1; bus.len_i = 6'd8;
        bus.vld_i = 1'b1; bus.data_i = 32'h0BADF00D; #1;
        chk("clr_rdy", 32'(bus.rdy_o), 32'd0);
        tick();
        set_idle();
        chk("clr_fill", 32'(bus.fill_o), 32'd0);
        chk("clr_data", bus.data_o, 32'h0);

        // Drain a final word with a short last field
        bus.vld_i = 1'b1; bus.last_i = 1'b1; bus.data_i = 32'hA5A5A5A5; tick();
        set_idle();
        chk("drain_rdy0", 32'(bus.rdy_o), 32'd0);
        bus.rdy_i = 1'b1; bus.len_i = 6'd28;
        bus.vld_i = 1'b1; bus.data_i = 32'hFFFFFFFF; tick();
        set_idle();
        chk("drain_fill4", 32'(bus.fill_o), 32'd4);
        chk("drain_rdy", 32'(bus.rdy_o), 32'd0);
        bus.rdy_i = 1'b1; bus.len_i = 6'd8; #1;
        chk("drain_vld", 32'(bus.vld_o), 32'd1);
        chk("drain_last", 32'(bus.last_o), 32'd1);
        tick();
        set_idle();
        chk("idle_fill", 32'(bus.fill_o), 32'd0);
        chk("idle_rdy", 32'(bus.rdy_o), 32'd1);

        // Back-to-back full-width words
        bus.rdy_i = 1'b1; bus.len_i = 6'd32; bus.vld_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.data_i = $urandom();
            #1;
            if (i > 0) chk("tput_vld", 32'(bus.vld_o), 32'd1);
            chk("tput_rdy", 32'(bus.rdy_o), 32'd1);
            tick();
        end
        set_idle();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rst_i       = ($urandom_range(0, 199) == 0);
            clr_i       = ($urandom_range(0, 79) == 0);
            bus.vld_i   = ($urandom_range(0, 9) < 7);
            bus.last_i  = ($urandom_range(0, 19) == 0);
            bus.data_i  = $urandom();
            bus.rdy_i   = ($urandom_range(0, 3) != 0);
            bus.len_i   = 6'($urandom_range(0, OUT_W));
            bus.align_i = ($urandom_range(0, 15) == 0);
            tick();
        end
        rst_i = 1'b0;
        set_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
